seq_counter16_en: RTL and testbench

- Reference user design for the eFPGA flow: a 16-bit synchronous up-counter with synchronous reset and count enable, driven through a 28-bit padded user-I/O interface.
- Serves as the gold model that the fabric implementation (bitstream-loaded) is compared against bit-for-bit on io_out and ~io_oeb every cycle.

---
 rtl/seq_counter16_en_if.sv | 22 ++
 rtl/seq_counter16_en.sv | 95 +++++++++
 tb/tb_seq_counter16_en.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_counter16_en_if.sv
// ---------------------------------------------------------------------------
// seq_counter16_en_if
// Padded user-I/O bundle for the seq_counter16_en reference design.
//
//   io_in  : pad inputs  (bit 0 = rst, bit 1 = en, bit 2 = dir when up/down)
//   io_out : pad outputs (counter value and terminal count)
//   io_oeb : pad output-enable bar (1 = pad is an input)
//
// Handshake: there is no valid/ready flow control on this bundle. io_in is
// sampled on every rising clk edge, and io_out/io_oeb are valid continuously.
// The master drives io_in; the slave drives io_out and io_oeb.
// ---------------------------------------------------------------------------
interface seq_counter16_en_if #(
  parameter int IO_W = 28
);
  logic [IO_W-1:0] io_in;
  logic [IO_W-1:0] io_out;
  logic [IO_W-1:0] io_oeb;

  modport master (output io_in, input io_out, input io_oeb);
  modport slave  (input io_in, output io_out, output io_oeb);
endinterface

// File: rtl/seq_counter16_en.sv
// ---------------------------------------------------------------------------
// seq_counter16_en
// Gold-model 16-bit synchronous counter with enable, exposed through a padded
// 28-bit user-I/O bus. The fabric implementation is compared against this
// design bit-for-bit on io_out and ~io_oeb.
//
// Ports
//   clk : system clock, all state updates on the rising edge
//   io  : seq_counter16_en_if.slave
//         io_in[0]  rst (synchronous, active-high, wins over en)
//         io_in[1]  en  (count enable)
//         io_in[2]  dir (0 = up, 1 = down) only with SEQ16_UPDOWN_EN
//         io_out[OUT_LSB +: WIDTH]  count
//         io_out[OUT_LSB + WIDTH]   tc (terminal count, combinational)
//         io_oeb    constant, 1 on the input pads
//
// Build option
//   SEQ16_UPDOWN_EN : when defined, io_in[2] selects the count direction and
//                     tc fires on 0 when counting down. Undefined by default.
// ---------------------------------------------------------------------------
module seq_counter16_en #(
  parameter int WIDTH   = 16,
  parameter int OUT_LSB = 2,
  parameter int IO_W    = 28
) (
  input  logic               clk,
  seq_counter16_en_if.slave  io
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

`ifdef SEQ16_UPDOWN_EN
  localparam logic [IO_W-1:0] OEB_VALUE = IO_W'(7);
`else
  localparam logic [IO_W-1:0] OEB_VALUE = IO_W'(3);
`endif

  logic             rst_i;
  logic             en_i;
  logic             tc_o;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [IO_W-1:0]  io_out_o;

  assign rst_i = io.io_in[0];
  assign en_i  = io.io_in[1];

`ifdef SEQ16_UPDOWN_EN
  logic dir_i;
  logic unused_in;
  assign dir_i     = io.io_in[2];
  assign unused_in = ^io.io_in[IO_W-1:3];
`else
  logic unused_in;
  assign unused_in = ^io.io_in[IO_W-1:2];
`endif

  // Next-state: reset beats enable; holding is the default.
  always_comb begin
    count_d = count_q;
    if (rst_i) begin
      count_d = '0;
    end else if (en_i) begin
`ifdef SEQ16_UPDOWN_EN
      count_d = dir_i ? (count_q - ONE) : (count_q + ONE);
`else
      count_d = count_q + ONE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  // tc flags the cycle just before the counter wraps in its current direction.
  always_comb begin
`ifdef SEQ16_UPDOWN_EN
    tc_o = en_i & ~rst_i & (dir_i ? (count_q == '0) : (count_q == ALL_ONES));
`else
    tc_o = en_i & ~rst_i & (count_q == ALL_ONES);
`endif
  end

  always_comb begin
    io_out_o                  = '0;
    io_out_o[OUT_LSB +: WIDTH] = count_q;
    io_out_o[OUT_LSB + WIDTH]  = tc_o;
  end

  assign io.io_out = io_out_o;
  assign io.io_oeb = OEB_VALUE;

endmodule

// File: tb/tb_seq_counter16_en.sv
module tb_seq_counter16_en;

  localparam int IO_W = 28;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  seq_counter16_en_if #(.IO_W(IO_W)) bus ();

  seq_counter16_en #(.WIDTH(16), .OUT_LSB(2), .IO_W(IO_W)) dut (
    .clk (clk),
    .io  (bus)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [IO_W-1:0] exp_q[$];

`ifdef SEQ16_UPDOWN_EN
  localparam logic [IO_W-1:0] EXP_OEB = 28'h0000007;
`else
  localparam logic [IO_W-1:0] EXP_OEB = 28'h0000003;
`endif

  // Reference model: an integer count kept in 0..65535 with modular arithmetic.
  int model_count = 0;
  bit model_valid = 1'b0;

  function automatic bit model_tc(input bit r, input bit e, input bit d);
`ifdef SEQ16_UPDOWN_EN
    if (d) return e && !r && (model_count == 0);
`endif
    return e && !r && (model_count == 65535);
  endfunction

  function automatic logic [IO_W-1:0] model_out(input bit r, input bit e, input bit d);
    int v;
    v = model_count * 4 + (model_tc(r, e, d) ? (1 << 18) : 0);
    return IO_W'(v);
  endfunction

  function automatic void model_step(input bit r, input bit e, input bit d);
    if (r) begin
      model_count = 0;
      model_valid = 1'b1;
    end else if (e) begin
      int delta = 1;
`ifdef SEQ16_UPDOWN_EN
      if (d) delta = 65535;
`endif
      model_count = (model_count + delta) % 65536;
    end
  endfunction

  task automatic chk(input string name, input logic [IO_W-1:0] act, input logic [IO_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%07h expected 0x%07h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, check outputs against the model,
  // advance through one rising edge, return at the next falling edge.
  task automatic cycle(input bit r, input bit e, input bit d, input logic [IO_W-4:0] junk);
    bus.io_in = {junk, d, e, r};
    #1;
    if (model_valid) begin
      exp_q.push_back(model_out(r, e, d));
      chk("io_out", bus.io_out, exp_q.pop_front());
    end
    chk("io_oeb", bus.io_oeb, EXP_OEB);
    @(posedge clk);
    model_step(r, e, d);
    @(negedge clk);
  endtask

  task automatic run(input bit r, input bit e, input int n);
    for (int i = 0; i < n; i++) cycle(r, e, 1'b0, '0);
  endtask

  function automatic logic [IO_W-1:0] count_field(input logic [IO_W-1:0] v);
    return {10'd0, v[17:2], 2'b00};
  endfunction

  typedef struct {
    bit              r;
    bit              e;
    logic [15:0]     exp_count;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bus.io_in = '0;
    vecs[0] = '{1'b1, 1'b1, 16'd0};
    vecs[1] = '{1'b0, 1'b1, 16'd1};
    vecs[2] = '{1'b0, 1'b1, 16'd2};
    vecs[3] = '{1'b0, 1'b0, 16'd2};
    vecs[4] = '{1'b0, 1'b1, 16'd3};
    vecs[5] = '{1'b1, 1'b0, 16'd0};
    vecs[6] = '{1'b0, 1'b1, 16'd1};
    vecs[7] = '{1'b1, 1'b1, 16'd0};
    vecs[8] = '{1'b0, 1'b0, 16'd0};
    vecs[9] = '{1'b0, 1'b1, 16'd1};
    @(negedge clk);

    // Reset with enable held
    run(1'b1, 1'b1, 5);
    chk("reset_out", bus.io_out, 28'h0000000);
    chk("reset_oeb", bus.io_oeb, EXP_OEB);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].r, vecs[i].e, 1'b0, '0);
      bus.io_in = '0;
      #1;
      chk($sformatf("vec%0d", i), count_field(bus.io_out), {10'd0, vecs[i].exp_count, 2'b00});
    end

    // 100 enabled cycles from reset
    run(1'b1, 1'b0, 1);
    run(1'b0, 1'b1, 100);
    bus.io_in = '0;
    #1;
    chk("count100", bus.io_out, 28'h0000190);

    // Hold at 5 then resume
    run(1'b1, 1'b0, 1);
    run(1'b0, 1'b1, 5);
    run(1'b0, 1'b0, 10);
    bus.io_in = '0;
    #1;
    chk("hold5", bus.io_out, 28'h0000014);
    run(1'b0, 1'b1, 1);
    bus.io_in = '0;
    #1;
    chk("resume6", bus.io_out, 28'h0000018);

    // Mid-operation reset at 0x1234
    run(1'b1, 1'b0, 1);
    run(1'b0, 1'b1, 16'h1234);
    bus.io_in = '0;
    #1;
    chk("pre_rst_1234", bus.io_out, 28'h00048D0);
    run(1'b1, 1'b1, 1);
    bus.io_in = '0;
    #1;
    chk("mid_rst", bus.io_out, 28'h0000000);
    run(1'b0, 1'b1, 1);
    bus.io_in = '0;
    #1;
    chk("after_rst", bus.io_out, 28'h0000004);

    // Wrap-around
    run(1'b1, 1'b0, 1);
    run(1'b0, 1'b1, 65535);
    bus.io_in = 28'h2;
    #1;
    chk("tc_at_ffff", bus.io_out, 28'h007FFFC);
    bus.io_in = 28'h0;
    #1;
    chk("tc_no_en", bus.io_out, 28'h003FFFC);
    bus.io_in = 28'h3;
    #1;
    chk("tc_rst", bus.io_out, 28'h003FFFC);
    run(1'b0, 1'b1, 1);
    bus.io_in = 28'h2;
    #1;
    chk("wrap_zero", bus.io_out, 28'h0000000);

`ifdef SEQ16_UPDOWN_EN
    run(1'b1, 1'b0, 1);
    bus.io_in = 28'h6;
    #1;
    chk("dn_tc_at_0", bus.io_out, 28'h0040000);
    cycle(1'b0, 1'b1, 1'b1, '0);
    bus.io_in = 28'h6;
    #1;
    chk("dn_ffff", bus.io_out, 28'h003FFFC);
    cycle(1'b0, 1'b1, 1'b1, '0);
    bus.io_in = 28'h6;
    #1;
    chk("dn_fffe", bus.io_out, 28'h003FFF8);
`endif

    // Randomized stimulus against the model (upper bits carry junk)
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            bit'($urandom_range(0, 1)), (IO_W-3)'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
